sparse_mxv_row_sched: RTL and testbench

- Row scheduler for the sparse matrix-vector engine.
- Walks a row-descriptor table and, for each matrix row, arms the engine and streams that row's packed weight/index words from weight memory.
- Waits a fixed drain time, then hands the 16-bit row result to the downstream collector over a valid/ready port.
- The x vector (inputx) is wired externally to the engine and must be held stable while busy=1.

---
 rtl/sparse_mxv_row_sched.sv | 130 +++++++++++++
 tb/tb_sparse_mxv_row_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sparse_mxv_row_sched.sv
// Row scheduler for the sparse matrix-vector engine: walks the row-descriptor
// table, streams each row's weight words into the engine and emits per-row results.
module sparse_mxv_row_sched #(
  parameter int unsigned ROWS   = 64,
  parameter int unsigned ROW_W  = 6,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 14,
  parameter int unsigned DRAIN  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [ROW_W-1:0]        tbl_addr,
  input  logic [ADDR_W+LEN_W-1:0] tbl_data,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_rd_addr,
  input  logic [51:0]             w_rd_data,
  output logic                    eng_idle,
  output logic [31:0]             eng_inputw,
  output logic [19:0]             eng_inputw_index,
  output logic [13:0]             eng_counter,
  input  logic [15:0]             eng_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ROW_W-1:0]        res_row,
  output logic [15:0]             res_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TBL_RD, ST_TBL_CAP, ST_ARM, ST_STREAM, ST_DRAIN, ST_EMIT, ST_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                rd_pend_q;
  logic [ADDR_W-1:0]   tbl_base;
  logic [LEN_W-1:0]    tbl_len;
  logic                last_row;

  assign tbl_base  = tbl_data[ADDR_W+LEN_W-1:LEN_W];
  assign tbl_len   = tbl_data[LEN_W-1:0];
  assign last_row  = (row_q == ROW_W'(ROWS - 1));
  assign tbl_addr  = row_q;
  assign w_rd_addr = addr_q;

  // abort gates the handshake/strobe outputs in the same cycle it is seen
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done      = (state_q == ST_FIN) && !abort;
  assign w_rd_en   = (state_q == ST_STREAM) && !abort;
  assign res_valid = (state_q == ST_EMIT) && !abort;
  assign eng_idle  = abort || !((state_q == ST_STREAM) || (state_q == ST_DRAIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_TBL_RD;
      ST_TBL_RD:  state_d = ST_TBL_CAP;
      ST_TBL_CAP: state_d = (tbl_len == '0) ? ST_EMIT : ST_ARM;
      ST_ARM:     state_d = ST_STREAM;
      ST_STREAM:  if (cnt_q == LEN_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN:   if (cnt_q == '0) state_d = ST_EMIT;
      ST_EMIT:    if (res_ready) state_d = last_row ? ST_FIN : ST_TBL_RD;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q            <= '0;
      addr_q           <= '0;
      cnt_q            <= '0;
      rd_pend_q        <= 1'b0;
      eng_inputw       <= '0;
      eng_inputw_index <= '0;
      eng_counter      <= '0;
      res_row          <= '0;
      res_data         <= '0;
    end else begin
      rd_pend_q <= w_rd_en;
      // memory data arrives the cycle after the read; every other cycle pads with zero
      if (rd_pend_q && !abort) begin
        eng_inputw       <= w_rd_data[31:0];
        eng_inputw_index <= w_rd_data[51:32];
      end else begin
        eng_inputw       <= '0;
        eng_inputw_index <= '0;
      end
      unique case (state_q)
        ST_IDLE: if (start) row_q <= '0;
        ST_TBL_CAP: begin
          addr_q      <= tbl_base;
          cnt_q       <= tbl_len;
          eng_counter <= 14'(tbl_len);
          if (tbl_len == '0) begin
            res_data <= '0;
            res_row  <= row_q;
          end
        end
        // cnt_q counts remaining issues, then is reloaded for the drain wait
        ST_STREAM: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= (cnt_q == LEN_W'(1)) ? LEN_W'(DRAIN - 1) : cnt_q - LEN_W'(1);
        end
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            res_data <= eng_result;
            res_row  <= row_q;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        ST_EMIT: if (res_ready && !last_row && !abort) row_q <= row_q + ROW_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_mxv_row_sched.sv
// Directed bench: row table vectors with hand/model expected results, plus
// abort and asynchronous-reset sequences; engine modelled as a byte accumulator.
module tb_sparse_mxv_row_sched;

  localparam int unsigned DRAIN_C = 6;

  logic        clk = 1'b0;
  logic        rst, start, abort, res_ready;
  logic        busy, done, w_rd_en, eng_idle, res_valid;
  logic [5:0]  tbl_addr, res_row;
  logic [27:0] tbl_data;
  logic [13:0] w_rd_addr, eng_counter;
  logic [51:0] w_rd_data;
  logic [31:0] eng_inputw;
  logic [19:0] eng_inputw_index;
  logic [15:0] eng_result, res_data, acc;

  sparse_mxv_row_sched #(.ROWS(64), .ROW_W(6), .ADDR_W(14), .LEN_W(14), .DRAIN(DRAIN_C)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data), .eng_idle(eng_idle), .eng_inputw(eng_inputw),
    .eng_inputw_index(eng_inputw_index), .eng_counter(eng_counter), .eng_result(eng_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] base;
    logic [13:0] len;
    int unsigned stall;
    logic [15:0] exp_data;
    int unsigned exp_lat;
  } vec_t;

  vec_t        vec [64];
  logic [51:0] mem [16384];
  int unsigned issued [64];
  logic        idle_low [64];
  int          checks = 0;
  int          errors = 0;
  logic        mon_on = 1'b0;
  logic        hung = 1'b0;
  logic        p1_en = 1'b0, p2_en = 1'b0;
  logic [13:0] p1_addr = '0, p2_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bsum(input logic [31:0] w);
    return 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
  endfunction

  function automatic logic [15:0] row_sum(input logic [13:0] base, input logic [13:0] len);
    logic [15:0] s;
    logic [13:0] a;
    s = '0;
    for (int unsigned k = 0; k < len; k++) begin
      a = base + 14'(k);
      s = s + bsum(mem[a][31:0]);
    end
    return s;
  endfunction

  // table/weight memories (1-cycle read) and engine: x = 1.0, so products equal weights
  always @(posedge clk) begin
    tbl_data <= {vec[tbl_addr].base, vec[tbl_addr].len};
    if (w_rd_en) w_rd_data <= mem[w_rd_addr];
    acc <= eng_idle ? 16'd0 : acc + bsum(eng_inputw);
  end
  assign eng_result = acc;

  always @(negedge clk) begin
    logic [13:0] ea;
    if (mon_on) begin
      if (w_rd_en) begin
        ea = vec[tbl_addr].base + 14'(issued[tbl_addr]);
        chk("rd_addr", 64'(w_rd_addr), 64'(ea));
        issued[tbl_addr]++;
      end
      if (!eng_idle) begin
        idle_low[tbl_addr] = 1'b1;
        chk("inputw", 64'({eng_inputw_index, eng_inputw}), p2_en ? 64'(mem[p2_addr]) : 64'd0);
      end
    end
    p2_en = p1_en; p2_addr = p1_addr;
    p1_en = w_rd_en; p1_addr = w_rd_addr;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, w_rd_en, res_valid, eng_idle, tbl_addr, res_row, res_data}),
        64'({5'b00001, 28'd0}));
    chk({tag, "_eng"}, 64'({eng_inputw, eng_inputw_index}), 64'd0);
    chk({tag, "_cnt"}, 64'({eng_counter, w_rd_addr}), 64'd0);
  endtask

  task automatic wait_issue(input logic level, output logic ok);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (w_rd_en !== level && n < 100);
    ok = (w_rd_en === level);
    if (!ok) chk("wait_w_rd_en", 64'(w_rd_en), 64'(level));
  endtask

  initial begin
    logic ok;
    int n, dn;
    rst = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    for (int a = 0; a < 16384; a++) begin
      mem[a] = {20'(a * 7 + 3), 8'(a), 8'(a), 8'(a), 8'h01};
    end
    for (int a = 16; a < 19; a++) mem[a][31:0] = 32'h01010101;
    for (int r = 0; r < 64; r++) begin
      vec[r].base  = 14'($urandom_range(0, 16383));
      vec[r].len   = 14'($urandom_range(0, 20));
      vec[r].stall = 0;
    end
    vec[0].base = 14'h0010; vec[0].len = 14'd3;
    vec[1].base = 14'h0100; vec[1].len = 14'd0;
    vec[2].base = 14'h3FFE; vec[2].len = 14'd4; vec[2].stall = 5;
    vec[10].stall = 2;
    for (int r = 0; r < 64; r++) begin
      vec[r].exp_data = row_sum(vec[r].base, vec[r].len);
      vec[r].exp_lat  = (vec[r].len == 0) ? 3 : 4 + int'(vec[r].len) + DRAIN_C;
      issued[r] = 0;
      idle_low[r] = 1'b0;
    end
    vec[0].exp_data = 16'd12;
    vec[1].exp_data = 16'd0;
    vec[2].exp_data = 16'd1534;

    #2 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // full pass over all 64 rows
    mon_on = 1'b1;
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    for (int r = 0; r < 64 && !hung; r++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!res_valid && n < 200);
      if (!res_valid) begin
        chk("res_valid_timeout", 64'(res_valid), 64'd1);
        hung = 1'b1;
      end else begin
        chk("latency", 64'(n), 64'(vec[r].exp_lat));
        chk("res_row", 64'(res_row), 64'(r));
        chk("res_data", 64'(res_data), 64'(vec[r].exp_data));
        chk("eng_counter", 64'(eng_counter), 64'(vec[r].len));
        chk("issue_count", 64'(issued[r]), 64'(vec[r].len));
        if (vec[r].len == 0) chk("len0_engine_held", 64'(idle_low[r]), 64'd0);
        for (int d = 0; d < int'(vec[r].stall); d++) begin
          start = (r == 10 && d == 0);
          @(negedge clk);
          start = 1'b0;
          chk("backpressure_hold", 64'({res_valid, res_row, res_data, tbl_addr}),
              64'({1'b1, 6'(r), vec[r].exp_data, 6'(r)}));
        end
        res_ready = 1'b1; @(posedge clk); #1 res_ready = 1'b0;
      end
    end
    if (!hung) begin
      @(negedge clk);
      chk("done_pulse", 64'({done, busy}), 64'b10);
      @(negedge clk);
      chk("done_clear", 64'({done, busy}), 64'b00);
    end
    mon_on = 1'b0;

    // abort during STREAM
    if (!hung) begin
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_issue(1'b1, ok);
      if (ok) begin
        abort = 1'b1;
        #1 chk("abort_same_cycle", 64'({w_rd_en, res_valid, eng_idle}), 64'b001);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'({busy, w_rd_en, eng_idle}), 64'b001);
        dn = 0;
        repeat (30) begin @(negedge clk); if (done || busy) dn++; end
        chk("abort_no_done", 64'(dn), 64'd0);
      end
    end

    // asynchronous reset mid-DRAIN
    if (!hung) begin
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      wait_issue(1'b1, ok);
      if (ok) wait_issue(1'b0, ok);
      if (ok) begin
        @(negedge clk);
        chk("in_drain", 64'({busy, eng_idle, eng_counter}), 64'({1'b1, 1'b0, 14'd3}));
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 64'({busy, done, w_rd_en}), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
